// File: rtl/rx_frame_len.sv
// Counts bytes per received frame and queues (length-1) in a FWFT circular buffer.
// Define RX_FRAME_STATS_EN to add the frame_cnt / drop_cnt statistics outputs.
module rx_frame_len #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld,
    input  logic        frame_end,
    output logic [10:0] cnt,
    output logic        cnt_vld,
    input  logic        cnt_rdy,
    output logic        frame_ovf,
    output logic        len_err
`ifdef RX_FRAME_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, RX} state_t;

    state_t        state;
    logic [11:0]   byte_cnt;
    logic [10:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] occ;

    logic [11:0]   eff_cnt;
    logic [10:0]   push_val;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;

    // A byte arriving together with frame_end still belongs to the ending frame.
    always_comb begin
        eff_cnt = byte_cnt;
        if (byte_vld && byte_cnt != 12'd2048)
            eff_cnt = byte_cnt + 12'd1;
    end

    assign push_val = 11'(eff_cnt - 12'd1);
    assign push     = frame_end && (eff_cnt != 12'd0);
    assign full     = (occ == OW'(DEPTH));
    assign pop      = cnt_vld && cnt_rdy;
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;

    assign cnt_vld  = (occ != '0);
    assign cnt      = cnt_vld ? mem[rd_ptr] : 11'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= 12'd0;
            frame_ovf <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (byte_vld && !frame_end) state <= RX;
                RX:      if (frame_end) state <= IDLE;
                default: state <= IDLE;
            endcase
            byte_cnt  <= frame_end ? 12'd0 : eff_cnt;
            frame_ovf <= drop;
            len_err   <= push && eff_cnt[11];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_val;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef RX_FRAME_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
            drop_cnt  <= 8'd0;
        end else begin
            if (push_ok)
                frame_cnt <= frame_cnt + 16'd1;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_frame_len.sv
// Bench for rx_frame_len: queue-based reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_rx_frame_len;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_vld = 1'b0;
    logic        frame_end = 1'b0;
    logic        cnt_rdy = 1'b0;
    logic [10:0] cnt;
    logic        cnt_vld;
    logic        frame_ovf;
    logic        len_err;
`ifdef RX_FRAME_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rx_frame_len #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_vld  (byte_vld),
        .frame_end (frame_end),
        .cnt       (cnt),
        .cnt_vld   (cnt_vld),
        .cnt_rdy   (cnt_rdy),
        .frame_ovf (frame_ovf),
        .len_err   (len_err)
`ifdef RX_FRAME_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame's length is the number of bytes seen up to and
    // including frame_end, capped at 2048; queue holds length-1.
    int q[$];
    int bcount    = 0;
    bit exp_ovf   = 0;
    bit exp_lerr  = 0;
    int exp_frames = 0;
    int exp_drops  = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                bcount   = 0;
                exp_ovf  = 0;
                exp_lerr = 0;
                exp_frames = 0;
                exp_drops  = 0;
            end else begin
                int  len;
                bit  do_pop;
                do_pop   = (q.size() > 0) && cnt_rdy;
                len      = bcount + (byte_vld ? 1 : 0);
                if (len > 2048) len = 2048;
                exp_ovf  = 0;
                exp_lerr = 0;
                if (do_pop) void'(q.pop_front());
                if (frame_end) begin
                    if (len >= 1) begin
                        exp_lerr = (len == 2048);
                        if (q.size() == DEPTH) begin
                            exp_ovf = 1;
                            if (exp_drops < 255) exp_drops++;
                        end else begin
                            q.push_back(len - 1);
                            exp_frames = (exp_frames + 1) % 65536;
                        end
                    end
                    bcount = 0;
                end else begin
                    bcount = len;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cnt_vld", int'(cnt_vld), (q.size() != 0) ? 1 : 0);
        if (q.size() != 0)
            chk("cnt_head", int'(cnt), q[0]);
        chk("frame_ovf", int'(frame_ovf), int'(exp_ovf));
        chk("len_err", int'(len_err), int'(exp_lerr));
`ifdef RX_FRAME_STATS_EN
        chk("frame_cnt", int'(frame_cnt), exp_frames);
        chk("drop_cnt", int'(drop_cnt), exp_drops);
`endif
    end

    task automatic bytes(input int n);
        byte_vld = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        byte_vld = 1'b0;
    endtask

    task automatic end_cycle(input logic bv);
        byte_vld  = bv;
        frame_end = 1'b1;
        @(posedge clk); #1;
        byte_vld  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic frame(input int n, input bit merged);
        if (merged) begin
            bytes(n - 1);
            end_cycle(1'b1);
        end else begin
            bytes(n);
            end_cycle(1'b0);
        end
    endtask

    initial begin
        int exp_list[4];

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cnt_vld", int'(cnt_vld), 0);
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_frame_ovf", int'(frame_ovf), 0);
        chk("reset_len_err", int'(len_err), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 64 bytes, separate frame_end, consumer ready
        cnt_rdy = 1'b1;
        frame(64, 0);
        $display("frame 64 bytes: cnt=%0d cnt_vld=%0d", cnt, cnt_vld);
        chk("f64_vld", int'(cnt_vld), 1);
        chk("f64_cnt", int'(cnt), 63);
        @(posedge clk); #1;
        chk("f64_vld_one_cycle", int'(cnt_vld), 0);

        // 60 bytes with frame_end on the last byte
        frame(60, 1);
        $display("frame 60 bytes merged end: cnt=%0d", cnt);
        chk("f60_cnt", int'(cnt), 59);
        @(posedge clk); #1;

        // Overflow: five frames into a four-entry queue with no consumer
        cnt_rdy = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            frame(10 * i, 0);
            $display("frame %0d bytes (stalled): frame_ovf=%0d", 10 * i, frame_ovf);
        end
        chk("ovf_pulse", int'(frame_ovf), 1);
        chk("ovf_head", int'(cnt), 9);
`ifdef RX_FRAME_STATS_EN
        @(posedge clk); #1;
        chk("ovf_drop_cnt", int'(drop_cnt), 1);
`else
        @(posedge clk); #1;
`endif
        chk("ovf_single_pulse", int'(frame_ovf), 0);
        exp_list = '{9, 19, 29, 39};
        cnt_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("ovf_drain", int'(cnt), exp_list[k]);
            @(posedge clk); #1;
        end
        chk("ovf_drained", int'(cnt_vld), 0);

        // Full queue, pop and push in the same cycle
        cnt_rdy = 1'b0;
        for (int i = 1; i <= DEPTH; i++) frame(i, 0);
        bytes(4);
        byte_vld = 1'b1; frame_end = 1'b1; cnt_rdy = 1'b1;
        @(posedge clk); #1;
        byte_vld = 1'b0; frame_end = 1'b0; cnt_rdy = 1'b0;
        $display("full push+pop: frame_ovf=%0d cnt=%0d", frame_ovf, cnt);
        chk("fullpp_no_ovf", int'(frame_ovf), 0);
        chk("fullpp_head", int'(cnt), 1);
        exp_list = '{1, 2, 3, 4};
        cnt_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("fullpp_drain", int'(cnt), exp_list[k]);
            @(posedge clk); #1;
        end

        // Oversized frame, then an empty frame_end
        frame(3000, 0);
        $display("frame 3000 bytes: cnt=%0d len_err=%0d", cnt, len_err);
        chk("long_cnt", int'(cnt), 2047);
        chk("long_len_err", int'(len_err), 1);
        @(posedge clk); #1;
        chk("long_len_err_once", int'(len_err), 0);
        end_cycle(1'b0);
        $display("empty frame_end: cnt_vld=%0d", cnt_vld);
        chk("empty_no_push", int'(cnt_vld), 0);

        // Reset mid-frame with two entries queued
        cnt_rdy = 1'b0;
        frame(3, 0);
        frame(4, 0);
        bytes(5);
        rst = 1'b1;
        #1;
        $display("async reset: cnt_vld=%0d cnt=%0d", cnt_vld, cnt);
        chk("rst_cnt_vld", int'(cnt_vld), 0);
        chk("rst_cnt", int'(cnt), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        end_cycle(1'b0);
        chk("rst_empty_end", int'(cnt_vld), 0);
        cnt_rdy = 1'b1;
        frame(8, 0);
        $display("frame 8 bytes after reset: cnt=%0d", cnt);
        chk("post_rst_cnt", int'(cnt), 7);
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
